// File: rtl/serial_tx.sv
// Parallel-to-serial transmitter: one BIT_SIZE-bit word per valid/ready accept, shifted out MSB-first,
// DIV clocks per bit. Define SERIAL_TX_PARITY_EN to append one odd-parity bit period after the data.
module serial_tx #(
    parameter int BIT_SIZE = 8,
    parameter int DIV      = 9,
    parameter int CNT_W    = 4
) (
    input  logic                clk,
    input  logic                i_sclr,
    input  logic                i_valid,
    input  logic [BIT_SIZE-1:0] i_data,
    output logic                o_ready,
    output logic                o_dat,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_en
);

    localparam int BC_W = (BIT_SIZE > 1) ? $clog2(BIT_SIZE) : 1;

    if (DIV < 2 || DIV > 15) begin : g_div_range
        $error("serial_tx: DIV=%0d outside legal range 2..15", DIV);
    end
    if ((DIV - 1) >= (1 << CNT_W)) begin : g_cnt_width
        $error("serial_tx: CNT_W=%0d cannot hold DIV-1=%0d", CNT_W, DIV - 1);
    end

`ifdef SERIAL_TX_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
    logic par_q;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

    state_t              state_q;
    logic [BIT_SIZE-1:0] sr_q;
    logic [BIT_SIZE-1:0] sr_d;
    logic [CNT_W-1:0]    div_q;
    logic [BC_W-1:0]     bcnt_q;
    logic                dat_q;
    logic                done_q;
    logic                en_q;
    logic                tick;

    // en_q is set one clock early so it is high exactly while div_q == DIV-1
    assign tick = (div_q == CNT_W'(DIV - 1));
    assign sr_d = sr_q << 1;

    always_ff @(posedge clk or posedge i_sclr) begin
        if (i_sclr) begin
            state_q <= IDLE;
            sr_q    <= '0;
            div_q   <= '0;
            bcnt_q  <= '0;
            dat_q   <= 1'b0;
            done_q  <= 1'b0;
            en_q    <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            en_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    div_q <= '0;
                    dat_q <= 1'b0;
                    if (i_valid) begin
                        state_q <= SHIFT;
                        sr_q    <= i_data;
                        bcnt_q  <= '0;
                        dat_q   <= i_data[BIT_SIZE-1];
`ifdef SERIAL_TX_PARITY_EN
                        par_q   <= ~^i_data;
`endif
                    end
                end
                SHIFT: begin
                    if (tick) begin
                        div_q  <= '0;
                        sr_q   <= sr_d;
                        bcnt_q <= bcnt_q + 1'b1;
                        dat_q  <= sr_d[BIT_SIZE-1];
                        if (bcnt_q == BC_W'(BIT_SIZE - 1)) begin
`ifdef SERIAL_TX_PARITY_EN
                            state_q <= PAR;
                            dat_q   <= par_q;
`else
                            state_q <= IDLE;
                            dat_q   <= 1'b0;
                            done_q  <= 1'b1;
`endif
                        end
                    end else begin
                        div_q <= div_q + 1'b1;
                        en_q  <= (div_q == CNT_W'(DIV - 2));
                    end
                end
`ifdef SERIAL_TX_PARITY_EN
                PAR: begin
                    if (tick) begin
                        div_q   <= '0;
                        state_q <= IDLE;
                        dat_q   <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        div_q <= div_q + 1'b1;
                        en_q  <= (div_q == CNT_W'(DIV - 2));
                    end
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_ready = (state_q == IDLE);
    assign o_busy  = (state_q != IDLE);
    assign o_dat   = dat_q;
    assign o_done  = done_q;
    assign o_en    = en_q;

endmodule

// File: tb/tb_serial_tx.sv
// Scoreboard bench for serial_tx: accepted words are queued, and a negedge monitor acting as the
// receiver (sampling o_dat on o_en) checks every frame against the queue head when o_done pulses.
module tb_serial_tx;

    localparam int BS = 8;
    localparam int DV = 9;
`ifdef SERIAL_TX_PARITY_EN
    localparam int NB = BS + 1;
`else
    localparam int NB = BS;
`endif
    localparam int FRAME = NB * DV;

    logic          clk = 1'b0;
    logic          i_sclr = 1'b1;
    logic          i_valid = 1'b0;
    logic [BS-1:0] i_data = '0;
    logic          o_ready, o_dat, o_busy, o_done, o_en;

    serial_tx #(.BIT_SIZE(BS), .DIV(DV), .CNT_W(4)) dut (
        .clk     (clk),
        .i_sclr  (i_sclr),
        .i_valid (i_valid),
        .i_data  (i_data),
        .o_ready (o_ready),
        .o_dat   (o_dat),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_en    (o_en)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    endtask

    logic [BS-1:0] sb[$];

    // receiver-side monitor state
    int          nb_cyc    = 0;
    int          ne_cyc    = 0;
    int          bad_bits  = 0;
    int          rdy_bad   = 0;
    int          done_cnt  = 0;
    logic        prev_done = 1'b0;
    logic [NB-1:0] rx      = '0;

    always @(negedge clk) begin
        if (i_sclr) begin
            nb_cyc = 0; ne_cyc = 0; bad_bits = 0; rdy_bad = 0; rx = '0;
            prev_done = 1'b0;
        end else begin
            if (o_busy) begin
                logic [BS-1:0] cur;
                logic          eb;
                int            idx;
                cur = (sb.size() > 0) ? sb[0] : '0;
                idx = nb_cyc / DV;
                if (idx < BS) eb = cur[BS-1-idx];
                else          eb = ~^cur;
                if (o_dat !== eb) bad_bits++;
                if (o_ready) rdy_bad++;
                nb_cyc++;
                if (o_en) begin
                    ne_cyc++;
                    rx = {rx[NB-2:0], o_dat};
                end
            end
            if (o_done) begin
                logic [BS-1:0] e;
                done_cnt++;
                chk("done_width", prev_done, 1'b0);
                chk("sb_depth", sb.size(), 1);
                e = (sb.size() > 0) ? sb.pop_front() : '0;
                chk("frame_len", nb_cyc, FRAME);
                chk("en_ticks", ne_cyc, NB);
                chk("bit_hold_err", bad_bits, 0);
                chk("ready_low_err", rdy_bad, 0);
                chk("done_ready", o_ready, 1'b1);
                chk("done_busy", o_busy, 1'b0);
`ifdef SERIAL_TX_PARITY_EN
                chk("rx_data", rx[NB-1:1], e);
                chk("parity", rx[0], ~^e);
`else
                chk("rx_data", rx, e);
`endif
                nb_cyc = 0; ne_cyc = 0; bad_bits = 0; rdy_bad = 0; rx = '0;
            end
            prev_done = o_done;
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge with i_valid still high.
    task automatic accept(input logic [BS-1:0] w);
        int t = 0;
        i_valid = 1'b1;
        i_data  = w;
        while (!o_ready && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("accept_ready", o_ready, 1'b1);
        @(posedge clk);
        sb.push_back(w);
        @(negedge clk);
    endtask

    task automatic wait_done(input int n);
        int t = 0;
        while (done_cnt < n && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk("done_seen", done_cnt, n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        // reset, then idle with i_valid low
        repeat (3) @(negedge clk);
        i_sclr = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("idle_ready", o_ready, 1'b1);
            chk("idle_dat", o_dat, 1'b0);
            chk("idle_busy", o_busy, 1'b0);
            chk("idle_en", o_en, 1'b0);
            chk("idle_done", o_done, 1'b0);
        end

        // single frame A5, then loopback 3C
        accept(8'hA5);
        i_valid = 1'b0;
        wait_done(1);
        repeat (3) @(negedge clk);
        accept(8'h3C);
        i_valid = 1'b0;
        wait_done(2);
        repeat (2) @(negedge clk);

        // back-to-back with i_valid held; i_data changes mid-frame
        accept(8'hFF);
        repeat (20) @(negedge clk);
        i_data = 8'h00;
        chk("b2b_midframe_busy", o_busy, 1'b1);
        accept(8'h00);
        chk("b2b_done_at_accept", done_cnt, 3);
        i_data = 8'h5A;
        repeat (30) @(negedge clk);
        i_valid = 1'b0;
        wait_done(4);
        repeat (2) @(negedge clk);

        // async reset at clock 30 of an 81 frame
        accept(8'h81);
        i_valid = 1'b0;
        repeat (29) @(posedge clk);
        #2;
        d0 = done_cnt;
        i_sclr = 1'b1;
        sb.delete();
        #1;
        chk("rst_busy", o_busy, 1'b0);
        chk("rst_dat", o_dat, 1'b0);
        chk("rst_en", o_en, 1'b0);
        chk("rst_done", o_done, 1'b0);
        repeat (2) @(negedge clk);
        i_sclr = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_no_done", done_cnt, d0);
        chk("rst_ready", o_ready, 1'b1);
        accept(8'h81);
        i_valid = 1'b0;
        wait_done(d0 + 1);
        repeat (2) @(negedge clk);

        // parity patterns (plain frames when parity is disabled)
        accept(8'h07);
        i_valid = 1'b0;
        wait_done(d0 + 2);
        accept(8'h03);
        i_valid = 1'b0;
        wait_done(d0 + 3);

        // a few random words
        for (int k = 0; k < 4; k++) begin
            accept(BS'($urandom_range(0, 255)));
            i_valid = 1'b0;
            wait_done(d0 + 4 + k);
        end

        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/serial_tx.md
Name: serial_tx

Overview:
Parallel-to-serial transmitter that sits directly upstream of the serial receiver and drives its i_dat line.
- Accepts one BIT_SIZE-bit word through a valid/ready handshake.
- Shifts the word out MSB-first, one bit per bit period of DIV clocks, from an internal enable divider.
- Signals frame completion with a one-cycle done pulse.

Parameters:
BIT_SIZE, 8, data word width and number of data bits per frame
DIV, 9, clocks per bit period (50 MHz / 9 bit rate); legal range 2..15
CNT_W, 4, width of the divider counter; must hold DIV-1

Ports:
clk  input  1  system clock, rising edge
i_sclr  input  1  reset, asynchronous, active-high; clears all state
i_valid  input  1  upstream has a word on i_data
i_data  input  BIT_SIZE  word to transmit; sampled only at accept
o_ready  output  1  block can accept a word (high only in IDLE)
o_dat  output  1  serial data line to the receiver
o_busy  output  1  frame in progress
o_done  output  1  one-cycle pulse when the last bit period ends
o_en  output  1  bit-period tick, for monitoring and debug

Behaviour:
- Reset (async, i_sclr=1):
  - state=IDLE; shift register=0; divider=0; bit counter=0.
  - o_dat=0, o_busy=0, o_done=0, o_en=0, o_ready=1 after release.
- States: IDLE, SHIFT, PAR (PAR only when the optional feature is enabled).
- IDLE:
  - o_ready=1, o_busy=0, o_dat=0 (idle level).
  - Accept happens on a clock edge where i_valid=1 and o_ready=1.
  - At accept: shift register <= i_data; divider <= 0; bit counter <= 0; state <= SHIFT.
- SHIFT:
  - o_ready=0, o_busy=1, o_dat = shift register MSB, registered.
  - First data bit appears on o_dat the cycle after accept.
  - Divider counts 0..DIV-1 and wraps; o_en=1 when divider==DIV-1, so each bit is held exactly DIV clocks.
  - On o_en: shift register shifts left with 0 fill; bit counter increments.
  - On o_en with bit counter==BIT_SIZE-1:
    - Without the feature: state <= IDLE and o_done=1 on the next cycle.
    - With the feature: go to PAR.
- Frame length: BIT_SIZE*DIV clocks from the cycle after accept until o_busy falls; 72 clocks at defaults.
- o_done is registered. It is high during the first IDLE cycle, the same cycle o_ready returns to 1.
- Back-to-back frames:
  - A word may be accepted in that first IDLE cycle, while o_done=1.
  - Next first bit follows with zero gap cycles.
- i_valid while busy is ignored; i_data is not re-sampled mid-frame.
- i_valid=0 in IDLE: divider is held at 0, o_en stays 0.
- Reset mid-frame: everything returns to reset values immediately, with no o_done. The partial frame is discarded.
- DIV outside 2..15 is illegal; simulation shall $error at elaboration.

Optional Feature:
Macro: SERIAL_TX_PARITY_EN
- Defined:
  - After the last data bit, state PAR drives one extra bit period (DIV clocks).
  - Parity bit is odd parity: XOR of all accepted data bits, inverted.
  - o_done pulses after PAR ends.
  - Frame length becomes (BIT_SIZE+1)*DIV clocks.
- Not defined: no PAR state, no parity logic; frame length BIT_SIZE*DIV.

Test Plan:
- Reset then idle: assert i_sclr for 3 cycles, release, i_valid=0 for 20 cycles -> o_ready=1, o_dat=0, o_busy=0, o_en=0, o_done=0 throughout.
- Single frame: i_data=8'hA5 with a one-cycle i_valid, DIV=9 -> o_dat shows 1,0,1,0,0,1,0,1, each bit exactly 9 cycles; o_busy high for 72 cycles; one o_done pulse; o_ready low for 72 cycles.
- Loopback: connect o_dat to the receiver's i_dat on the same enable phase, send 8'h3C -> receiver parallel output equals 8'h3C.
- Back-to-back: keep i_valid=1 with 8'hFF then 8'h00 -> second frame accepted in the o_done cycle; o_dat is 1 for 72 cycles, then 0 for 72 cycles with no gap; i_data changes mid-frame have no effect.
- Reset mid-frame: assert i_sclr asynchronously at clock 30 of an 8'h81 frame -> outputs clear before the next edge; no o_done; next frame 8'h81 transmits correctly.
- With SERIAL_TX_PARITY_EN: send 8'h07 -> 8 data bits then parity bit 0 for 9 cycles; o_done at clock 81. Send 8'h03 -> parity bit 1.
